regfile_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback controller for the 16-entry × 16-bit register file and the ALU. It fetches 16-bit instructions over a req/ready handshake and holds the program counter. It drives the register file read/write addresses and write enable, and drives the ALU opcode and immediate operand. It sits between instruction memory and the register-file/ALU datapath and is the only writer of the register file's control inputs.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/instr_decoder.sv | 71 +++++++
 rtl/regfile_sequencer.sv | 102 ++++++++++
 tb/tb_regfile_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcode, ALU operation and state encodings for the instruction sequencer
// and the register-file/ALU datapath it controls.
package seq_pkg;

    localparam logic [15:0] PC_RESET = 16'h0000;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_BRZ   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_PASSA = 4'hA;
    localparam logic [3:0] ALU_PASSB = 4'hB;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched instruction into register-file addresses,
// ALU controls, immediate operand and instruction-class flags.
module instr_decoder
    import seq_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [3:0]  read_a_o,
    output logic [3:0]  read_b_o,
    output logic [3:0]  write_addr_o,
    output logic [3:0]  alu_op_o,
    output logic        imm_sel_o,
    output logic [15:0] imm_value_o,
    output logic        writes_reg_o,
    output logic        is_branch_o,
    output logic        is_halt_o
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
    logic [7:0] imm8;

    assign op   = ir_i[15:12];
    assign rd   = ir_i[11:8];
    assign ext  = ir_i[7:4];
    assign rs   = ir_i[3:0];
    assign imm8 = ir_i[7:0];

    always_comb begin
        read_a_o     = rd;
        read_b_o     = rs;
        write_addr_o = rd;
        alu_op_o     = ALU_ADD;
        imm_sel_o    = 1'b0;
        imm_value_o  = 16'h0000;
        writes_reg_o = 1'b0;
        is_branch_o  = 1'b0;
        is_halt_o    = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_op_o     = ext;
                writes_reg_o = 1'b1;
            end
            OP_ADDI: begin
                alu_op_o     = ALU_ADD;
                imm_sel_o    = 1'b1;
                imm_value_o  = sext8(imm8);
                writes_reg_o = 1'b1;
            end
            OP_MOVI: begin
                alu_op_o     = ALU_PASSB;
                imm_sel_o    = 1'b1;
                imm_value_o  = {8'h00, imm8};
                writes_reg_o = 1'b1;
            end
            OP_BRZ: begin
                // ALU passes rd through so Flag_Z reflects rd == 0
                alu_op_o    = ALU_PASSA;
                imm_value_o = sext8(imm8);
                is_branch_o = 1'b1;
            end
            OP_HALT: begin
                is_halt_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-phase fetch/decode/execute/writeback controller: owns PC and IR, fetches
// over a req/ready handshake and drives the register file and ALU controls.
module regfile_sequencer
    import seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    input  logic        instr_ready_i,
    input  logic [15:0] instr_data_i,
    output logic [15:0] pc_o,
    output logic [3:0]  reg_read_a_o,
    output logic [3:0]  reg_read_b_o,
    output logic [3:0]  reg_write_o,
    output logic        write_enable_o,
    output logic [3:0]  alu_op_o,
    output logic        imm_sel_o,
    output logic [15:0] imm_value_o,
    input  logic        flag_z_i,
    output logic        halt_o
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        take_br_q, take_br_d;
    logic        started_q;

    logic        writes_reg;
    logic        is_branch;
    logic        is_halt;

    instr_decoder u_decoder (
        .ir_i         (ir_q),
        .read_a_o     (reg_read_a_o),
        .read_b_o     (reg_read_b_o),
        .write_addr_o (reg_write_o),
        .alu_op_o     (alu_op_o),
        .imm_sel_o    (imm_sel_o),
        .imm_value_o  (imm_value_o),
        .writes_reg_o (writes_reg),
        .is_branch_o  (is_branch),
        .is_halt_o    (is_halt)
    );

    // started_q keeps Instr_Req low until the first edge after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= 16'h0000;
            take_br_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            take_br_q <= take_br_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        take_br_d      = take_br_q;
        instr_req_o    = 1'b0;
        write_enable_o = 1'b0;
        halt_o         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req_o = started_q;
                if (started_q && instr_ready_i) begin
                    ir_d    = instr_data_i;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                take_br_d = is_branch & flag_z_i;
                state_d   = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                write_enable_o = writes_reg;
                pc_d           = take_br_q ? (pc_q + sext8(ir_q[7:0])) : (pc_q + 16'd1);
                state_d        = is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench: a driver plays instruction programs and pushes ISA-level
// expectations; an independent monitor pops them on fetches and register writes.
module tb_regfile_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_o;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] pc_o;
    logic [3:0]  reg_read_a_o, reg_read_b_o, reg_write_o, alu_op_o;
    logic        write_enable_o, imm_sel_o, halt_o;
    logic [15:0] imm_value_o;
    logic        flag_z;

    regfile_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_o    (instr_req_o),
        .instr_ready_i  (instr_ready),
        .instr_data_i   (instr_data),
        .pc_o           (pc_o),
        .reg_read_a_o   (reg_read_a_o),
        .reg_read_b_o   (reg_read_b_o),
        .reg_write_o    (reg_write_o),
        .write_enable_o (write_enable_o),
        .alu_op_o       (alu_op_o),
        .imm_sel_o      (imm_sel_o),
        .imm_value_o    (imm_value_o),
        .flag_z_i       (flag_z),
        .halt_o         (halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        int          waits;
    } prog_t;

    typedef struct {
        logic [15:0] pc;
        int          interval;
    } fexp_t;

    typedef struct {
        logic [3:0]  waddr;
        logic [3:0]  alu;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        imm_sel;
        logic [15:0] imm;
        bit          chk_ra;
        bit          chk_rb;
        bit          chk_imm;
    } wexp_t;

    prog_t prog_q[$];
    fexp_t fexp_q[$];
    wexp_t wexp_q[$];

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_pc = 16'h0000;
    bit          drv_en   = 1'b0;
    bit          in_fetch = 1'b0;
    int          waits_left = 0;
    prog_t       cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int soff(input logic [7:0] v);
        int u;
        u = int'(v);
        return (u >= 128) ? (u - 256) : u;
    endfunction

    // ISA-level reference: what one instruction at model_pc must do
    task automatic model_issue(input prog_t p);
        fexp_t       f;
        wexp_t       w;
        logic [3:0]  op;
        logic [7:0]  imm8;
        int          next;
        op   = p.instr[15:12];
        imm8 = p.instr[7:0];
        f.pc = model_pc;
        f.interval = 4 + p.waits;
        fexp_q.push_back(f);
        w.waddr = p.instr[11:8];
        w.ra = p.instr[11:8];
        w.rb = p.instr[3:0];
        w.chk_ra = 1'b1;
        w.chk_rb = 1'b0;
        w.chk_imm = 1'b1;
        next = int'(model_pc) + 1;
        case (op)
            4'h0: begin
                w.alu = p.instr[7:4]; w.imm_sel = 1'b0; w.imm = 16'h0;
                w.chk_rb = 1'b1; w.chk_imm = 1'b0;
                wexp_q.push_back(w);
            end
            4'h5: begin
                w.alu = ALU_ADD; w.imm_sel = 1'b1;
                w.imm = 16'((soff(imm8) + 65536) % 65536);
                wexp_q.push_back(w);
            end
            4'hD: begin
                w.alu = ALU_PASSB; w.imm_sel = 1'b1; w.imm = 16'(int'(imm8));
                w.chk_ra = 1'b0;
                wexp_q.push_back(w);
            end
            4'h4: if (p.z) next = int'(model_pc) + soff(imm8);
            default: ;
        endcase
        model_pc = 16'((next + 65536) % 65536);
    endtask

    function automatic prog_t rand_instr();
        prog_t      p;
        logic [3:0] op;
        int         r;
        r = $urandom_range(0, 8);
        case (r)
            0, 1: op = 4'h0;
            2, 3: op = 4'h5;
            4, 5: op = 4'hD;
            6, 7: op = 4'h4;
            default: begin
                op = 4'h1;
                for (int k = 0; k < 8; k++) begin
                    op = 4'($urandom_range(1, 14));
                    if (op != 4'h4 && op != 4'h5 && op != 4'hD) break;
                end
                if (op == 4'h4 || op == 4'h5 || op == 4'hD) op = 4'h1;
            end
        endcase
        p.instr = {op, 12'($urandom)};
        p.z     = 1'($urandom_range(0, 1));
        p.waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        return p;
    endfunction

    function automatic prog_t mk(input logic [15:0] i, input logic z, input int w);
        prog_t p;
        p.instr = i; p.z = z; p.waits = w;
        return p;
    endfunction

    // Driver: answers fetches after a per-instruction wait; junk outside FETCH
    always @(posedge clk) begin
        #1;
        if (rst || !drv_en) begin
            instr_ready = 1'b0;
        end else if (instr_req_o) begin
            if (!in_fetch) begin
                instr_ready = 1'b0;
                if (prog_q.size() != 0) begin
                    cur = prog_q.pop_front();
                    in_fetch = 1'b1;
                    waits_left = cur.waits;
                end
            end
            if (in_fetch) begin
                if (waits_left > 0) begin
                    waits_left--;
                    instr_ready = 1'b0;
                    instr_data = 16'($urandom);
                end else begin
                    instr_ready = 1'b1;
                    instr_data = cur.instr;
                    flag_z = cur.z;
                    model_issue(cur);
                    in_fetch = 1'b0;
                end
            end
        end else begin
            instr_ready = 1'($urandom_range(0, 1));
            instr_data = 16'($urandom);
        end
    end

    int    cyc = 0;
    int    last_hs = 0;
    bit    last_vld = 1'b0;
    fexp_t mf;
    wexp_t mw;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (instr_req_o && instr_ready) begin
                if (fexp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fetch_unexpected pc=%0h required=none", pc_o);
                end else begin
                    mf = fexp_q.pop_front();
                    check("fetch_pc", 32'(pc_o), 32'(mf.pc));
                    if (last_vld) check("fetch_interval", 32'(cyc - last_hs), 32'(mf.interval));
                    last_hs = cyc;
                    last_vld = 1'b1;
                end
            end
            if (write_enable_o) begin
                if (wexp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL write_unexpected waddr=%0h required=none", reg_write_o);
                end else begin
                    mw = wexp_q.pop_front();
                    check("wr_addr", 32'(reg_write_o), 32'(mw.waddr));
                    check("wr_alu_op", 32'(alu_op_o), 32'(mw.alu));
                    check("wr_imm_sel", 32'(imm_sel_o), 32'(mw.imm_sel));
                    if (mw.chk_imm) check("wr_imm_value", 32'(imm_value_o), 32'(mw.imm));
                    if (mw.chk_ra) check("wr_read_a", 32'(reg_read_a_o), 32'(mw.ra));
                    if (mw.chk_rb) check("wr_read_b", 32'(reg_read_b_o), 32'(mw.rb));
                end
            end
        end
    end

    task automatic flush();
        drv_en = 1'b0;
        in_fetch = 1'b0;
        prog_q.delete();
        fexp_q.delete();
        wexp_q.delete();
        last_vld = 1'b0;
        model_pc = PC_RESET;
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        rst = 1'b1;
        flush();
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic run_episode(input string tag);
        bit ok;
        drv_en = 1'b1;
        for (int i = 0; i < 3000 && !halt_o; i++) begin
            @(posedge clk); #2;
        end
        check({tag, "_halt_reached"}, 32'(halt_o), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (instr_req_o || write_enable_o || !halt_o) ok = 1'b0;
        end
        check({tag, "_halt_hold"}, 32'(ok), 32'd1);
        check({tag, "_sb_drained"}, 32'(fexp_q.size() + wexp_q.size() + prog_q.size()), 32'd0);
        reset_dut();
    endtask

    initial begin
        rst = 1'b1;
        instr_ready = 1'b0;
        instr_data = 16'h0000;
        flag_z = 1'b0;
        #12;
        check("rst_instr_req", 32'(instr_req_o), 32'd0);
        check("rst_pc", 32'(pc_o), 32'(PC_RESET));
        check("rst_write_enable", 32'(write_enable_o), 32'd0);
        check("rst_halt", 32'(halt_o), 32'd0);
        check("rst_read_a", 32'(reg_read_a_o), 32'd0);
        check("rst_read_b", 32'(reg_read_b_o), 32'd0);
        check("rst_reg_write", 32'(reg_write_o), 32'd0);
        check("rst_alu_op", 32'(alu_op_o), 32'd0);
        check("rst_imm_sel", 32'(imm_sel_o), 32'd0);
        check("rst_imm_value", 32'(imm_value_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("req_before_first_edge", 32'(instr_req_o), 32'd0);
        @(posedge clk); #1;
        check("req_after_first_edge", 32'(instr_req_o), 32'd1);

        // MOVI, ADDI with 3 wait cycles, BRZ taken and not taken at PC 5, HALT
        prog_q.push_back(mk(16'hD37F, 1'b0, 0));
        prog_q.push_back(mk(16'h53FF, 1'b0, 3));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h42FE, 1'b1, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h42FE, 1'b0, 0));
        prog_q.push_back(mk(16'hD001, 1'b1, 0));
        prog_q.push_back(mk(16'hF000, 1'b0, 0));
        run_episode("directed");

        // Branch back from 0 to FFFF, then a NOP wraps to 0000
        prog_q.push_back(mk(16'h42FF, 1'b1, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 1));
        prog_q.push_back(mk(16'h0912, 1'b0, 0));
        prog_q.push_back(mk(16'hF000, 1'b0, 0));
        run_episode("wrap");

        // Reset asserted during WRITEBACK of a MOVI at PC 2
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'h1000, 1'b0, 0));
        prog_q.push_back(mk(16'hD37F, 1'b0, 0));
        drv_en = 1'b1;
        for (int i = 0; i < 100 && !write_enable_o; i++) begin
            @(posedge clk); #2;
        end
        check("midwb_we_seen", 32'(write_enable_o), 32'd1);
        check("midwb_pc_before", 32'(pc_o), 32'd2);
        rst = 1'b1;
        #1;
        check("midwb_we_drop", 32'(write_enable_o), 32'd0);
        check("midwb_req_drop", 32'(instr_req_o), 32'd0);
        check("midwb_pc_reset", 32'(pc_o), 32'(PC_RESET));
        flush();
        #3 rst = 1'b0;
        #1 check("midwb_req_before_edge", 32'(instr_req_o), 32'd0);
        @(posedge clk); #1;
        check("midwb_req_after_edge", 32'(instr_req_o), 32'd1);
        check("midwb_no_write_after", 32'(write_enable_o), 32'd0);

        for (int e = 0; e < 4; e++) begin
            for (int n = 0; n < 40; n++) prog_q.push_back(rand_instr());
            prog_q.push_back(mk(16'hF000, 1'b0, 0));
            run_episode("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
